// File: rtl/fire_dispatch.sv
// fire_dispatch: drains fired-neuron tags and streams (dst, weight) synaptic events.
// Optional macro SKIP_ZERO_EN drops zero-weight events before they reach the output buffer.
module fire_dispatch #(
  parameter int numneurons = 2,
  parameter int tagbits = 1,
  parameter int weightbits = 16
) (
  input  logic                  clk,
  input  logic                  asyn_reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  input  logic                  fifo_empty,
  input  logic [tagbits-1:0]    fifo_tag,
  output logic                  fifo_deq,
  output logic                  w_ren,
  output logic [2*tagbits-1:0]  w_addr,
  input  logic [weightbits-1:0] w_data,
  output logic                  syn_valid,
  input  logic                  syn_ready,
  output logic [tagbits-1:0]    syn_dst,
  output logic [weightbits-1:0] syn_weight,
  output logic [tagbits:0]      spike_count
);
  localparam int cw = tagbits + 1;
  typedef enum logic [1:0] {IDLE, POP, SCAN, FLUSH} state_t;
  state_t r_state, w_next;
  logic [tagbits-1:0] r_src, r_if_dst;
  logic [cw-1:0] r_dst;
  logic r_inflight, r_wp, r_rp;
  logic [1:0] r_cnt;
  logic [2*tagbits-1:0] r_waddr;
  logic [tagbits-1:0] r_bd [2];
  logic [weightbits-1:0] r_bw [2];
  logic w_pop, w_push, w_credit, w_issue, w_last, w_drained;
  assign w_pop = syn_valid && syn_ready;
`ifdef SKIP_ZERO_EN
  assign w_push = r_inflight && (w_data != '0);
`else
  assign w_push = r_inflight;
`endif
  // An entry popping this cycle already frees its slot, keeping full rate with ready high.
  assign w_credit = (r_cnt - 2'(w_pop) + 2'(r_inflight)) < 2'd2;
  assign w_issue = (r_state == SCAN) && w_credit;
  assign w_last = r_dst == cw'(numneurons - 1);
  assign w_drained = (r_cnt == 2'd0) && !r_inflight;
  assign busy = r_state != IDLE;
  assign w_ren = w_issue;
  assign w_addr = w_issue ? {r_src, r_dst[tagbits-1:0]} : r_waddr;
  assign syn_valid = r_cnt != 2'd0;
  assign syn_dst = r_bd[r_rp];
  assign syn_weight = r_bw[r_rp];
  always_comb begin
    w_next = r_state;
    fifo_deq = 1'b0;
    case (r_state)
      IDLE: w_next = start ? POP : IDLE;
      POP: begin
        w_next = fifo_empty ? FLUSH : SCAN;
        fifo_deq = !fifo_empty;
      end
      SCAN: w_next = (w_issue && w_last) ? POP : SCAN;
      FLUSH: w_next = w_drained ? IDLE : FLUSH;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset) begin
      r_state <= IDLE;
      done <= 1'b0;
      spike_count <= '0;
      r_src <= '0;
      r_dst <= '0;
      r_if_dst <= '0;
      r_waddr <= '0;
      r_inflight <= 1'b0;
      r_wp <= 1'b0;
      r_rp <= 1'b0;
      r_cnt <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        r_bd[i] <= '0;
        r_bw[i] <= '0;
      end
    end else begin
      r_state <= w_next;
      done <= (r_state == FLUSH) && w_drained;
      if (r_state == IDLE && start) spike_count <= '0;
      if (fifo_deq) begin
        r_src <= fifo_tag;
        r_dst <= '0;
        if (~&spike_count) spike_count <= spike_count + cw'(1);
      end
      if (w_issue) begin
        r_dst <= r_dst + cw'(1);
        r_waddr <= w_addr;
        r_if_dst <= r_dst[tagbits-1:0];
      end
      r_inflight <= w_issue;
      if (w_push) begin
        r_bd[r_wp] <= r_if_dst;
        r_bw[r_wp] <= w_data;
        r_wp <= ~r_wp;
      end
      if (w_pop) r_rp <= ~r_rp;
      r_cnt <= r_cnt + 2'(w_push) - 2'(w_pop);
    end
  end
endmodule
